sal_refresh_scheduler: RTL and testbench

//  Per-rank DDR2 auto-refresh scheduler. Tracks tREFI per rank, accumulates refresh debt
//  (postponement up to MAX_POSTPONE), and requests REF from the command scheduler:

---
 rtl/sal_refresh_scheduler.sv | 179 +++++++++++++++++
 tb/tb_sal_refresh_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sal_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sal_refresh_scheduler
//  Purpose  : Per-rank DDR2 auto-refresh scheduler. Counts tREFI per rank,
//             accumulates postponed refresh debt, raises opportunistic or
//             urgent REF requests and holds the rank busy for tRFC after
//             each granted REF.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             cfg_ref_en         - refresh enable
//             cfg_trefi/cfg_trfc - refresh interval / refresh cycle time
//             rank_idle_i        - per-rank "no pending traffic"
//             ref_gnt_i          - per-rank REF issued pulse
//             ref_req_o          - per-rank refresh request
//             ref_urgent_o       - per-rank urgent refresh
//             rank_busy_o        - per-rank tRFC window active
//             debt_o             - per-rank debt, rank r at [4r+3:4r]
//             err_overflow_o     - sticky: tick while debt saturated
//             err_grant_o        - sticky: grant without request
//  Revision : 1.0 - initial release
// ============================================================================
module sal_refresh_scheduler #(
    parameter int NUM_RANK     = 2,
    parameter int TREFI_W      = 16,
    parameter int TRFC_W       = 8,
    parameter int MAX_POSTPONE = 8,
    parameter int URGENT_THR   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_ref_en,
    input  logic [TREFI_W-1:0]    cfg_trefi,
    input  logic [TRFC_W-1:0]     cfg_trfc,
    input  logic [NUM_RANK-1:0]   rank_idle_i,
    input  logic [NUM_RANK-1:0]   ref_gnt_i,
    output logic [NUM_RANK-1:0]   ref_req_o,
    output logic [NUM_RANK-1:0]   ref_urgent_o,
    output logic [NUM_RANK-1:0]   rank_busy_o,
    output logic [NUM_RANK*4-1:0] debt_o,
    output logic                  err_overflow_o,
    output logic                  err_grant_o
);

    localparam int         c_RANK_SH = $clog2(NUM_RANK);
    localparam logic [3:0] c_MAXP    = 4'(MAX_POSTPONE);
    localparam logic [3:0] c_URGENT  = 4'(URGENT_THR);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_COUNT    = 2'd1,
        ST_RFC      = 2'd2
    } state_t;

    // Effective timing values: tREFI floors at 2, tRFC floors at 1.
    logic [TREFI_W-1:0]  w_trefi_eff;
    logic [TREFI_W-1:0]  w_trefi_m1;
    logic [TRFC_W-1:0]   w_trfc_m1;
    logic [NUM_RANK-1:0] w_ovf_evt;
    logic [NUM_RANK-1:0] w_gnt_err;

    assign w_trefi_eff = (cfg_trefi < TREFI_W'(2)) ? TREFI_W'(2) : cfg_trefi;
    assign w_trefi_m1  = w_trefi_eff - TREFI_W'(1);
    assign w_trfc_m1   = (cfg_trfc == '0) ? '0 : cfg_trfc - TRFC_W'(1);

    for (genvar r = 0; r < NUM_RANK; r++) begin : g_rank
        localparam logic [TREFI_W-1:0] c_RIDX = TREFI_W'(r);

        state_t              r_state, w_state_nxt;
        logic [TREFI_W-1:0]  r_refi_cnt, w_refi_nxt;
        logic [TRFC_W-1:0]   r_rfc_cnt, w_rfc_nxt;
        logic [3:0]          r_debt, w_debt_nxt;
        logic                w_tick, w_gnt_ok, w_urgent, w_req;

        assign w_urgent = (r_state == ST_COUNT) && (r_debt >= c_URGENT);
        assign w_req    = (r_state == ST_COUNT) && (r_debt != 4'd0) &&
                          (rank_idle_i[r] || w_urgent);
        assign w_tick   = (r_state != ST_DISABLED) && (r_refi_cnt == '0);
        assign w_gnt_ok = ref_gnt_i[r] && w_req;

        assign w_gnt_err[r] = ref_gnt_i[r] && !w_req;
        assign w_ovf_evt[r] = w_tick && (r_debt == c_MAXP);

        assign ref_req_o[r]       = w_req;
        assign ref_urgent_o[r]    = w_urgent;
        assign rank_busy_o[r]     = (r_state == ST_RFC);
        assign debt_o[4*r +: 4]   = r_debt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= ST_DISABLED;
                r_refi_cnt <= '0;
                r_rfc_cnt  <= '0;
                r_debt     <= 4'd0;
            end else begin
                r_state    <= w_state_nxt;
                r_refi_cnt <= w_refi_nxt;
                r_rfc_cnt  <= w_rfc_nxt;
                r_debt     <= w_debt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_refi_nxt  = r_refi_cnt;
            w_rfc_nxt   = r_rfc_cnt;
            w_debt_nxt  = r_debt;

            // The tREFI counter keeps running through tRFC so that debt
            // accounting is not disturbed by refresh timing.
            if (r_state != ST_DISABLED) begin
                w_refi_nxt = w_tick ? w_trefi_m1 : r_refi_cnt - TREFI_W'(1);
                // Tick and grant together cancel; saturate at the limit.
                if (w_tick && !w_gnt_ok && (r_debt != c_MAXP)) begin
                    w_debt_nxt = r_debt + 4'd1;
                end else if (!w_tick && w_gnt_ok) begin
                    w_debt_nxt = r_debt - 4'd1;
                end
            end

            case (r_state)
                ST_DISABLED: begin
                    if (cfg_ref_en) begin
                        w_state_nxt = ST_COUNT;
                        // Stagger ranks across the interval.
                        w_refi_nxt  = w_trefi_m1 - c_RIDX * (w_trefi_eff >> c_RANK_SH);
                    end
                end
                ST_COUNT: begin
                    // A grant already issued on the bus must be honoured
                    // even if refresh is being disabled in the same cycle.
                    if (w_gnt_ok) begin
                        w_state_nxt = ST_RFC;
                        w_rfc_nxt   = w_trfc_m1;
                    end else if (!cfg_ref_en) begin
                        w_state_nxt = ST_DISABLED;
                        w_refi_nxt  = '0;
                        w_debt_nxt  = 4'd0;
                    end
                end
                ST_RFC: begin
                    if (r_rfc_cnt == '0) begin
                        if (cfg_ref_en) begin
                            w_state_nxt = ST_COUNT;
                        end else begin
                            w_state_nxt = ST_DISABLED;
                            w_refi_nxt  = '0;
                            w_debt_nxt  = 4'd0;
                        end
                    end else begin
                        w_rfc_nxt = r_rfc_cnt - TRFC_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_DISABLED;
                    w_refi_nxt  = '0;
                    w_rfc_nxt   = '0;
                    w_debt_nxt  = 4'd0;
                end
            endcase
        end
    end

    logic r_err_overflow;
    logic r_err_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
            r_err_grant    <= 1'b0;
        end else begin
            r_err_overflow <= r_err_overflow | (|w_ovf_evt);
            r_err_grant    <= r_err_grant | (|w_gnt_err);
        end
    end

    assign err_overflow_o = r_err_overflow;
    assign err_grant_o    = r_err_grant;

endmodule
`default_nettype wire

// File: tb/tb_sal_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sal_refresh_scheduler
//  Purpose  : Directed self-checking bench for sal_refresh_scheduler
//             (NUM_RANK=2, MAX_POSTPONE=8, URGENT_THR=6). Edge En is the
//             first rising edge with cfg_ref_en high after reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sal_refresh_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_ref_en;
    logic [15:0] cfg_trefi;
    logic [7:0]  cfg_trfc;
    logic [1:0]  rank_idle_i;
    logic [1:0]  ref_gnt_i;
    logic [1:0]  ref_req_o;
    logic [1:0]  ref_urgent_o;
    logic [1:0]  rank_busy_o;
    logic [7:0]  debt_o;
    logic        err_overflow_o;
    logic        err_grant_o;

    int n_checks = 0;
    int n_errors = 0;

    sal_refresh_scheduler #(
        .NUM_RANK     (2),
        .TREFI_W      (16),
        .TRFC_W       (8),
        .MAX_POSTPONE (8),
        .URGENT_THR   (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_ref_en     (cfg_ref_en),
        .cfg_trefi      (cfg_trefi),
        .cfg_trfc       (cfg_trfc),
        .rank_idle_i    (rank_idle_i),
        .ref_gnt_i      (ref_gnt_i),
        .ref_req_o      (ref_req_o),
        .ref_urgent_o   (ref_urgent_o),
        .rank_busy_o    (rank_busy_o),
        .debt_o         (debt_o),
        .err_overflow_o (err_overflow_o),
        .err_grant_o    (err_grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cfg_ref_en  = 1'b0;
        cfg_trefi   = 16'd100;
        cfg_trfc    = 8'd10;
        rank_idle_i = 2'b11;
        ref_gnt_i   = 2'b00;
        step();
        step();

        // ---------------- reset state ----------------
        chk("rst_req",    32'(ref_req_o),      32'h0);
        chk("rst_urg",    32'(ref_urgent_o),   32'h0);
        chk("rst_busy",   32'(rank_busy_o),    32'h0);
        chk("rst_debt",   32'(debt_o),         32'h0);
        chk("rst_errovf", 32'(err_overflow_o), 32'h0);
        chk("rst_errgnt", 32'(err_grant_o),    32'h0);

        // ---------------- test 1: trefi=100, trfc=10, stagger ----------------
        rst        = 1'b0;
        cfg_ref_en = 1'b1;
        step();                                       // E0
        chk("t1_e0_req", 32'(ref_req_o), 32'h0);
        repeat (49) step();                           // E49
        chk("t1_e49_req", 32'(ref_req_o), 32'h0);
        step();                                       // E50: rank1 tick
        chk("t1_e50_req",  32'(ref_req_o), 32'h2);
        chk("t1_e50_debt", 32'(debt_o),    32'h10);
        ref_gnt_i = 2'b10;
        step();                                       // E51: rank1 granted
        ref_gnt_i = 2'b00;
        chk("t1_e51_busy", 32'(rank_busy_o), 32'h2);
        chk("t1_e51_debt", 32'(debt_o),      32'h00);
        chk("t1_e51_req",  32'(ref_req_o),   32'h0);
        repeat (9) step();                            // E60: last busy cycle
        chk("t1_e60_busy", 32'(rank_busy_o), 32'h2);
        step();                                       // E61
        chk("t1_e61_busy", 32'(rank_busy_o), 32'h0);
        repeat (38) step();                           // E99
        chk("t1_e99_req", 32'(ref_req_o), 32'h0);
        step();                                       // E100: rank0 tick
        chk("t1_e100_req",  32'(ref_req_o), 32'h1);
        chk("t1_e100_debt", 32'(debt_o),    32'h01);
        ref_gnt_i = 2'b01;
        step();                                       // E101
        ref_gnt_i = 2'b00;
        chk("t1_e101_busy", 32'(rank_busy_o), 32'h1);
        chk("t1_e101_debt", 32'(debt_o),      32'h00);
        repeat (9) step();                            // E110
        chk("t1_e110_busy", 32'(rank_busy_o), 32'h1);
        step();                                       // E111
        chk("t1_e111_busy", 32'(rank_busy_o), 32'h0);
        chk("t1_e111_gerr", 32'(err_grant_o), 32'h0);

        // ---------------- test 4: spurious grant to rank0 ----------------
        ref_gnt_i = 2'b01;
        step();                                       // E112
        ref_gnt_i = 2'b00;
        chk("t4_gerr", 32'(err_grant_o), 32'h1);
        chk("t4_busy", 32'(rank_busy_o), 32'h0);
        chk("t4_debt", 32'(debt_o),      32'h00);
        chk("t4_req",  32'(ref_req_o),   32'h0);

        // ---------------- test 5: grant on tick edge with debt=1 ----------------
        repeat (187) step();                          // E299
        chk("t5_e299_debt", 32'(debt_o),    32'h21);
        chk("t5_e299_req",  32'(ref_req_o), 32'h3);
        ref_gnt_i = 2'b01;
        step();                                       // E300: rank0 tick + grant
        ref_gnt_i = 2'b00;
        chk("t5_e300_debt", 32'(debt_o),      32'h21);
        chk("t5_e300_busy", 32'(rank_busy_o), 32'h1);
        chk("t5_e300_req",  32'(ref_req_o),   32'h2);

        // ---------------- test 6a: disable mid-RFC ----------------
        cfg_ref_en = 1'b0;
        repeat (9) step();                            // E309
        chk("t6_e309_busy", 32'(rank_busy_o), 32'h1);
        chk("t6_e309_debt", 32'(debt_o),      32'h01);
        chk("t6_e309_req",  32'(ref_req_o),   32'h0);
        step();                                       // E310
        chk("t6_e310_busy", 32'(rank_busy_o),    32'h0);
        chk("t6_e310_debt", 32'(debt_o),         32'h00);
        chk("t6_e310_gerr", 32'(err_grant_o),    32'h1);
        chk("t6_e310_oerr", 32'(err_overflow_o), 32'h0);

        // ---------------- test 2: no idle, trefi=20, urgency ----------------
        rst         = 1'b1;
        cfg_trefi   = 16'd20;
        rank_idle_i = 2'b00;
        step();
        chk("t2_rst_gerr", 32'(err_grant_o), 32'h0);
        rst        = 1'b0;
        cfg_ref_en = 1'b1;
        step();                                       // E0
        repeat (119) step();                          // E119
        chk("t2_e119_debt", 32'(debt_o),       32'h65);
        chk("t2_e119_urg",  32'(ref_urgent_o), 32'h2);
        chk("t2_e119_req",  32'(ref_req_o),    32'h2);
        step();                                       // E120: rank0 6th tick
        chk("t2_e120_debt", 32'(debt_o),       32'h66);
        chk("t2_e120_urg",  32'(ref_urgent_o), 32'h3);
        chk("t2_e120_req",  32'(ref_req_o),    32'h3);
        ref_gnt_i = 2'b01;
        step();                                       // E121
        ref_gnt_i = 2'b00;
        chk("t2_e121_debt", 32'(debt_o),       32'h65);
        chk("t2_e121_busy", 32'(rank_busy_o),  32'h1);
        chk("t2_e121_urg",  32'(ref_urgent_o), 32'h2);

        // ---------------- test 3: saturation and overflow ----------------
        repeat (48) step();                           // E169
        chk("t3_e169_debt", 32'(debt_o),         32'h87);
        chk("t3_e169_oerr", 32'(err_overflow_o), 32'h0);
        step();                                       // E170: rank1 9th tick
        chk("t3_e170_debt", 32'(debt_o),         32'h87);
        chk("t3_e170_oerr", 32'(err_overflow_o), 32'h1);
        ref_gnt_i = 2'b10;
        step();                                       // E171
        ref_gnt_i = 2'b00;
        chk("t3_e171_debt", 32'(debt_o),         32'h77);
        chk("t3_e171_busy", 32'(rank_busy_o),    32'h2);
        chk("t3_e171_oerr", 32'(err_overflow_o), 32'h1);

        // ---------------- test 6b: async reset mid-RFC ----------------
        rst = 1'b1;
        #1;
        chk("t6_arst_busy", 32'(rank_busy_o),    32'h0);
        chk("t6_arst_debt", 32'(debt_o),         32'h00);
        chk("t6_arst_req",  32'(ref_req_o),      32'h0);
        chk("t6_arst_urg",  32'(ref_urgent_o),   32'h0);
        chk("t6_arst_oerr", 32'(err_overflow_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
